// File: rtl/gmii_rx_frame_checker_if.sv
// Payload beat stream leaving the GMII frame checker.
// There is no tready: the sink must take every beat.
interface gmii_rx_frame_checker_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tuser;

  modport master (output tdata, tvalid, tlast, tuser);
  modport slave  (input  tdata, tvalid, tlast, tuser);
endinterface

// File: rtl/gmii_rx_frame_checker.sv
// GMII transmit-side frame checker. Strips preamble/SFD/FCS, checks CRC-32, length and tx_er,
// and streams payload bytes out with a good/bad verdict on the last beat.
module gmii_rx_frame_checker #(
  parameter int MIN_PREAMBLE = 1,
  parameter int MIN_FRAME    = 64,
  parameter int MAX_FRAME    = 1522,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    gmii_tx_en,
  input  logic                    gmii_tx_er,
  input  logic [7:0]              gmii_txd,
  gmii_rx_frame_checker_if.master m,
  output logic                    rx_active,
  output logic [CNT_WIDTH-1:0]    good_cnt,
  output logic [CNT_WIDTH-1:0]    bad_cnt
);
  localparam int DLY    = 5;
  localparam int LEN_W  = $clog2(MAX_FRAME + 2);
  localparam int PCNT_W = $clog2(MIN_PREAMBLE + 2);
  localparam logic [LEN_W-1:0] LEN_SAT     = LEN_W'(MAX_FRAME + 1);
  localparam logic [7:0]       PRE_BYTE    = 8'h55;
  localparam logic [7:0]       SFD_BYTE    = 8'hD5;
  localparam logic [31:0]      CRC_RESIDUE = 32'hC704DD7B;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_DROP
  } state_t;

  state_t            state_reg;
  logic [PCNT_W-1:0] pcnt_reg;
  logic [LEN_W-1:0]  len_reg;
  logic              err_reg;
  logic [31:0]       crc_reg;
  logic [7:0]        dly_reg [DLY];

  logic [31:0] crc_rev;
  logic        dly_full;
  logic        pcnt_ok;
  logic        frame_bad;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // The register runs LSB-first; the residue constant is written MSB-first.
  for (genvar gi = 0; gi < 32; gi++) begin : g_crc_rev
    assign crc_rev[gi] = crc_reg[31-gi];
  end

  assign dly_full  = (len_reg >= LEN_W'(DLY));
  assign pcnt_ok   = (pcnt_reg >= PCNT_W'(MIN_PREAMBLE));
  assign frame_bad = err_reg || (crc_rev != CRC_RESIDUE) ||
                     (len_reg < LEN_W'(MIN_FRAME)) || (len_reg > LEN_W'(MAX_FRAME));
  assign rx_active = (state_reg == ST_PREAMBLE) || (state_reg == ST_DATA);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg <= ST_WAIT;
      pcnt_reg  <= '0;
      len_reg   <= '0;
      err_reg   <= 1'b0;
      crc_reg   <= '1;
      for (int i = 0; i < DLY; i++) begin
        dly_reg[i] <= '0;
      end
      m.tdata   <= '0;
      m.tvalid  <= 1'b0;
      m.tlast   <= 1'b0;
      m.tuser   <= 1'b0;
      good_cnt  <= '0;
      bad_cnt   <= '0;
    end else begin
      m.tvalid <= 1'b0;
      m.tlast  <= 1'b0;
      m.tuser  <= 1'b0;
      case (state_reg)
        // Held here after reset so a frame already in flight is never picked up halfway.
        ST_WAIT: begin
          if (!gmii_tx_en) state_reg <= ST_IDLE;
        end
        ST_IDLE: begin
          if (gmii_tx_en) begin
            if (gmii_txd == PRE_BYTE) begin
              state_reg <= ST_PREAMBLE;
              pcnt_reg  <= PCNT_W'(1);
            end else begin
              state_reg <= ST_DROP;
            end
          end
        end
        ST_PREAMBLE: begin
          if (!gmii_tx_en) begin
            state_reg <= ST_IDLE;
          end else if (gmii_txd == PRE_BYTE) begin
            if (pcnt_reg != '1) pcnt_reg <= pcnt_reg + 1'b1;
          end else if ((gmii_txd == SFD_BYTE) && pcnt_ok) begin
            state_reg <= ST_DATA;
            len_reg   <= '0;
            err_reg   <= 1'b0;
            crc_reg   <= '1;
          end else begin
            state_reg <= ST_DROP;
          end
        end
        ST_DATA: begin
          if (gmii_tx_en) begin
            crc_reg    <= crc_step(crc_reg, gmii_txd);
            dly_reg[0] <= gmii_txd;
            for (int i = 1; i < DLY; i++) begin
              dly_reg[i] <= dly_reg[i-1];
            end
            if (len_reg != LEN_SAT) len_reg <= len_reg + 1'b1;
            if (gmii_tx_er) err_reg <= 1'b1;
            // Holding back five bytes keeps the four FCS bytes off the stream.
            if (dly_full) begin
              m.tvalid <= 1'b1;
              m.tdata  <= dly_reg[DLY-1];
            end
          end else begin
            state_reg <= ST_IDLE;
            if (dly_full) begin
              m.tvalid <= 1'b1;
              m.tlast  <= 1'b1;
              m.tuser  <= frame_bad;
              m.tdata  <= dly_reg[DLY-1];
              if (frame_bad) bad_cnt <= sat_inc(bad_cnt);
              else           good_cnt <= sat_inc(good_cnt);
            end else begin
              bad_cnt <= sat_inc(bad_cnt);
            end
          end
        end
        ST_DROP: begin
          if (!gmii_tx_en) begin
            state_reg <= ST_IDLE;
            bad_cnt   <= sat_inc(bad_cnt);
          end
        end
        default: state_reg <= ST_WAIT;
      endcase
    end
  end
endmodule

// File: tb/tb_gmii_rx_frame_checker.sv
// Directed bench for gmii_rx_frame_checker: a frame-level model predicts every beat and
// counter change from the frame contents; a per-cycle compare checks two DUT instances.
module tb_gmii_rx_frame_checker;
  typedef logic [7:0] bq_t[$];
  typedef struct {
    int         cyc;
    logic [7:0] data;
    bit         last;
    bit         user;
  } beat_t;
  typedef struct {
    int cyc;
    bit good;
  } cev_t;

  logic        aclk       = 1'b0;
  logic        aresetn    = 1'b0;
  logic        gmii_tx_en = 1'b0;
  logic        gmii_tx_er = 1'b0;
  logic [7:0]  gmii_txd   = 8'h00;
  logic        rx_active, rx_active2;
  logic [15:0] good_cnt, bad_cnt;
  logic [1:0]  good_cnt2, bad_cnt2;

  gmii_rx_frame_checker_if m_if ();
  gmii_rx_frame_checker_if m2_if ();

  gmii_rx_frame_checker #(.CNT_WIDTH(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er), .gmii_txd(gmii_txd),
    .m(m_if), .rx_active(rx_active), .good_cnt(good_cnt), .bad_cnt(bad_cnt)
  );

  gmii_rx_frame_checker #(.CNT_WIDTH(2)) dut2 (
    .aclk(aclk), .aresetn(aresetn),
    .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er), .gmii_txd(gmii_txd),
    .m(m2_if), .rx_active(rx_active2), .good_cnt(good_cnt2), .bad_cnt(bad_cnt2)
  );

  always #4 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int    n_vec = 0;
  int    n_err = 0;
  beat_t beat_q[$];
  cev_t  cnt_q[$];
  int    mg = 0;
  int    mb = 0;
  int    beats_seen = 0;
  int    tlast_seen = 0;
  int    first_beat_cyc = -1;
  int    first_drive_cyc = -1;
  logic [7:0] last_data_seen = 8'h00;
  logic  last_user_seen = 1'b0;
  beat_t e_b;
  bit    exp_v;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Standard Ethernet FCS: reflected CRC-32, all-ones init, complemented result.
  function automatic logic [31:0] crc32(input bq_t b);
    logic [31:0] c;
    c = '1;
    foreach (b[i]) begin
      c = c ^ {24'h0, b[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic void push_beat(input int c, input logic [7:0] d, input bit l, input bit u);
    beat_t b;
    b.cyc = c; b.data = d; b.last = l; b.user = u;
    beat_q.push_back(b);
  endfunction

  function automatic void push_cnt(input int c, input bit g);
    cev_t ev;
    ev.cyc = c; ev.good = g;
    cnt_q.push_back(ev);
  endfunction

  // Per-cycle compare of both instances against the model.
  always @(negedge aclk) begin
    while (cnt_q.size() > 0 && cnt_q[0].cyc <= cyc) begin
      if (cnt_q[0].good) mg++; else mb++;
      void'(cnt_q.pop_front());
    end
    chk("good_cnt",  32'(good_cnt),  32'(sat(mg, 65535)));
    chk("bad_cnt",   32'(bad_cnt),   32'(sat(mb, 65535)));
    chk("good_cnt2", 32'(good_cnt2), 32'(sat(mg, 3)));
    chk("bad_cnt2",  32'(bad_cnt2),  32'(sat(mb, 3)));
    exp_v = (beat_q.size() > 0) && (beat_q[0].cyc == cyc);
    if (exp_v) e_b = beat_q[0];
    chk("beat_flags",  {30'd0, m_if.tvalid,  m_if.tlast},  {30'd0, exp_v, exp_v & e_b.last});
    chk("beat2_flags", {30'd0, m2_if.tvalid, m2_if.tlast}, {30'd0, exp_v, exp_v & e_b.last});
    if (exp_v) begin
      chk("beat_data",  32'(m_if.tdata),  32'(e_b.data));
      chk("beat2_data", 32'(m2_if.tdata), 32'(e_b.data));
      if (e_b.last) begin
        chk("beat_tuser",  32'(m_if.tuser),  32'(e_b.user));
        chk("beat2_tuser", 32'(m2_if.tuser), 32'(e_b.user));
      end
      void'(beat_q.pop_front());
    end
    if (m_if.tvalid) begin
      beats_seen++;
      if (first_beat_cyc < 0) first_beat_cyc = cyc;
      if (m_if.tlast) begin
        tlast_seen++;
        last_data_seen = m_if.tdata;
        last_user_seen = m_if.tuser;
      end
    end
  end

  task automatic drive(input logic en, input logic er, input logic [7:0] d, output int sc);
    @(negedge aclk);
    gmii_tx_en = en;
    gmii_tx_er = er;
    gmii_txd   = d;
    sc = cyc + 1;
  endtask

  task automatic idle(input int n);
    int sc;
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00, sc);
  endtask

  task automatic clear_stats();
    beats_seen = 0; tlast_seen = 0; first_beat_cyc = -1;
    last_data_seen = 8'h00; last_user_seen = 1'b0;
  endtask

  task automatic flush_model();
    beat_q.delete(); cnt_q.delete(); mg = 0; mb = 0;
  endtask

  task automatic do_reset();
    @(negedge aclk);
    #1 aresetn = 1'b0;
    flush_model();
    @(negedge aclk);
    chk("rst_tvalid", 32'(m_if.tvalid), 32'd0);
    chk("rst_active", 32'(rx_active),   32'd0);
    #1 aresetn = 1'b1;
  endtask

  // Sends preamble, SFD, payload and FCS; predicts beats and the verdict from frame content.
  task automatic send_frame(input bq_t pl, input int npre, input int flip_idx,
                            input int er_at, input int cut_at);
    bq_t         fr;
    bq_t         rp;
    logic [31:0] fcs;
    int          sc;
    int          n;
    bit          start_ok;
    bit          bad;
    fcs = crc32(pl);
    fr = pl;
    if (flip_idx >= 0) fr[flip_idx] = 8'hFF;
    fr.push_back(fcs[7:0]);
    fr.push_back(fcs[15:8]);
    fr.push_back(fcs[23:16]);
    fr.push_back(fcs[31:24]);
    n = fr.size();
    for (int i = 0; i < n - 4; i++) rp.push_back(fr[i]);
    start_ok = (npre >= 1);
    bad = ((er_at >= 0) && (er_at < n)) || (n < 64) || (n > 1522) ||
          (crc32(rp) != {fr[n-1], fr[n-2], fr[n-3], fr[n-4]});
    for (int i = 0; i < npre; i++) drive(1'b1, 1'b0, 8'h55, sc);
    drive(1'b1, 1'b0, 8'hD5, sc);
    for (int i = 0; i < n; i++) begin
      if (cut_at >= 0 && i == cut_at) return;
      drive(1'b1, (i == er_at), fr[i], sc);
      if (i == 0) first_drive_cyc = sc - 1;
      if (start_ok && i >= 5) push_beat(sc, fr[i-5], 1'b0, 1'b0);
    end
    drive(1'b0, 1'b0, 8'h00, sc);
    if (start_ok && n >= 5) begin
      push_beat(sc, fr[n-5], 1'b1, bad);
      push_cnt(sc, !bad);
    end else begin
      push_cnt(sc, 1'b0);
    end
  endtask

  initial begin
    bq_t p60, p59, p1, p0, pbig, pstr;
    int  sc;
    for (int i = 0; i < 60; i++) p60.push_back(8'(i));
    for (int i = 0; i < 59; i++) p59.push_back(8'(i + 7));
    p1.push_back(8'hA5);
    for (int i = 0; i < 1996; i++) pbig.push_back(8'(i * 3));
    for (int i = 0; i < 9; i++) pstr.push_back(8'(8'h31 + i));

    chk("model_crc_check", crc32(pstr), 32'hCBF43926);

    repeat (3) @(negedge aclk);
    chk("reset_tvalid", 32'(m_if.tvalid), 32'd0);
    chk("reset_good",   32'(good_cnt),    32'd0);
    #1 aresetn = 1'b1;
    idle(2);

    // 1: good frame, latency and order
    clear_stats();
    send_frame(p60, 7, -1, -1, -1);
    idle(3);
    chk("t1_beats",     32'(beats_seen),     32'd60);
    chk("t1_tlasts",    32'(tlast_seen),     32'd1);
    chk("t1_last_data", 32'(last_data_seen), 32'h3B);
    chk("t1_tuser",     32'(last_user_seen), 32'd0);
    chk("t1_good",      32'(good_cnt),       32'd1);
    chk("t1_latency",   32'(first_beat_cyc - first_drive_cyc), 32'd6);
    chk("t1_active",    32'(rx_active),      32'd0);

    // 2: corrupted payload byte, original FCS
    do_reset(); clear_stats();
    send_frame(p60, 7, 10, -1, -1);
    idle(3);
    chk("t2_beats", 32'(beats_seen),     32'd60);
    chk("t2_tuser", 32'(last_user_seen), 32'd1);
    chk("t2_bad",   32'(bad_cnt),        32'd1);
    chk("t2_good",  32'(good_cnt),       32'd0);

    // 3: tx_er mid-payload
    do_reset(); clear_stats();
    send_frame(p60, 7, -1, 30, -1);
    idle(3);
    chk("t3_tuser", 32'(last_user_seen), 32'd1);
    chk("t3_bad",   32'(bad_cnt),        32'd1);

    // 4: start errors
    do_reset(); clear_stats();
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 8'h00, sc);
    drive(1'b0, 1'b0, 8'h00, sc);
    push_cnt(sc, 1'b0);
    idle(3);
    chk("t4_beats", 32'(beats_seen), 32'd0);
    chk("t4_bad",   32'(bad_cnt),    32'd1);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'h55, sc);
    idle(3);
    chk("t4_short_pre_bad",  32'(bad_cnt),  32'd1);
    chk("t4_short_pre_good", 32'(good_cnt), 32'd0);
    send_frame(p60, 0, -1, -1, -1);
    idle(3);
    chk("t4_no_pre_beats", 32'(beats_seen), 32'd0);
    chk("t4_no_pre_bad",   32'(bad_cnt),    32'd2);

    // 5: back-to-back frames, length boundaries, oversize
    do_reset(); clear_stats();
    send_frame(p60, 7, -1, -1, -1);
    send_frame(p60, 1, -1, -1, -1);
    idle(3);
    chk("t5_beats",  32'(beats_seen), 32'd120);
    chk("t5_tlasts", 32'(tlast_seen), 32'd2);
    chk("t5_good",   32'(good_cnt),   32'd2);
    send_frame(p59, 7, -1, -1, -1);
    idle(2);
    chk("t5_len63_tuser", 32'(last_user_seen), 32'd1);
    send_frame(p0, 7, -1, -1, -1);
    send_frame(p1, 7, -1, -1, -1);
    idle(2);
    chk("t5_len5_data", 32'(last_data_seen), 32'hA5);
    send_frame(pbig, 7, -1, -1, -1);
    idle(2);
    chk("t5_big_tuser", 32'(last_user_seen), 32'd1);
    chk("t5_bad",       32'(bad_cnt),        32'd4);

    // 6: reset mid-payload with tx_en held high, then saturation of the narrow counters
    do_reset(); clear_stats();
    send_frame(p60, 7, -1, -1, 30);
    chk("t6_active_mid", 32'(rx_active), 32'd1);
    #1 aresetn = 1'b0;
    flush_model();
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'hAA, sc);
    chk("t6_rst_active", 32'(rx_active2), 32'd0);
    #1 aresetn = 1'b1;
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 8'hAA, sc);
    chk("t6_wait_active", 32'(rx_active), 32'd0);
    idle(2);
    send_frame(p60, 7, -1, -1, -1);
    idle(3);
    chk("t6_good", 32'(good_cnt), 32'd1);
    chk("t6_bad",  32'(bad_cnt),  32'd0);
    for (int f = 0; f < 4; f++) send_frame(p60, 7, -1, -1, -1);
    idle(3);
    chk("t6_good5",      32'(good_cnt),  32'd5);
    chk("t6_good_sat2",  32'(good_cnt2), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end
endmodule
